// File: rtl/mem_port_responder.sv
// mem_port_responder
//   Bridges the core's split imem/dmem word ports onto one burst-oriented
//   backing-memory port. Each request becomes a BURST_LEN x 64-bit line read.
//   Stores additionally merge their bytes into the fetched line and write
//   the whole line back. The selected 32-bit word returns with a one-cycle
//   resp pulse.
//
//   Build option: MEM_ARB_RR_EN
//     defined   -> round-robin between imem and dmem.
//     undefined -> fixed priority, dmem wins.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   imem_addr/rmask               instruction read request, held until resp
//   imem_rdata/resp               returned word and one-cycle completion pulse
//   dmem_addr/rmask/wmask/wdata   data request; wmask != 0 makes it a store
//   dmem_rdata/resp               returned word (the merged word for stores)
//                                 and one-cycle completion pulse
//   bmem_addr/read/write/wdata    line command and write beats, all registered
//   bmem_ready                    bmem accepts the command or beat this cycle
//   bmem_raddr/rdata/rvalid       returning read beats tagged with line address
module mem_port_responder #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [3:0]        imem_rmask,
    output logic [31:0]       imem_rdata,
    output logic              imem_resp,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [3:0]        dmem_rmask,
    input  logic [3:0]        dmem_wmask,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [63:0]       bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [63:0]       bmem_rdata,
    input  logic              bmem_rvalid
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int OFF_W = CNT_W + 3;  // byte-offset bits within one line

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEATS, WR_BEATS, RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    // The latched request. Only the in-line word offset is kept. The line
    // address lives in its own register.
    typedef struct packed {
        port_t            port;
        logic             wr;
        logic [OFF_W-3:0] off;   // {beat, half}
        logic [3:0]       wmask;
        logic [31:0]      wdata;
    } req_t;

    state_t                     state;
    req_t                       req;
    logic [ADDR_W-1:0]          line;
    logic [BURST_LEN-1:0][63:0] line_buf;
    logic [CNT_W-1:0]           cnt;   // fill slot in RD_BEATS, drain slot in WR_BEATS

    // Arbitration
    logic imem_req, dmem_req, pick_d;
    assign imem_req = |imem_rmask;
    assign dmem_req = (|dmem_rmask) | (|dmem_wmask);

`ifdef MEM_ARB_RR_EN
    port_t rr_ptr;  // port that wins a tie; flips away from whoever was just served
    assign pick_d = dmem_req & (~imem_req | (rr_ptr == PORT_D));
`else
    assign pick_d = dmem_req;
`endif

    logic [ADDR_W-1:0] win_addr;
    assign win_addr = pick_d ? dmem_addr : imem_addr;

    // The word-in-line offset comes from the line register and req.off.
    // Only the two byte-select bits are dropped here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{imem_addr[1:0], dmem_addr[1:0]};

    // Word select
    logic [CNT_W-1:0] sel_beat;
    logic             sel_half;
    assign sel_beat = req.off[OFF_W-3:1];
    assign sel_half = req.off[0];

    logic beat_ok;
    assign beat_ok = bmem_rvalid && (bmem_raddr == line);

    // fill_buf folds the incoming beat in during RD_BEATS. The last beat's
    // data is then visible to word select and merge in the same cycle it
    // arrives. Outside RD_BEATS it is simply the line buffer.
    logic [BURST_LEN-1:0][63:0] fill_buf, merged_buf;
    logic [31:0]                old_word, new_word;

    always_comb begin
        fill_buf = line_buf;
        if (state == RD_BEATS) fill_buf[cnt] = bmem_rdata;
    end

    assign old_word = sel_half ? fill_buf[sel_beat][63:32] : fill_buf[sel_beat][31:0];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign new_word[8*i +: 8] = req.wmask[i] ? req.wdata[8*i +: 8] : old_word[8*i +: 8];
    end

    always_comb begin
        merged_buf = fill_buf;
        if (sel_half) merged_buf[sel_beat][63:32] = new_word;
        else          merged_buf[sel_beat][31:0]  = new_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= '0;
            line       <= '0;
            line_buf   <= '0;
            cnt        <= '0;
            imem_resp  <= 1'b0;
            dmem_resp  <= 1'b0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= '0;
            bmem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= PORT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req || dmem_req) begin
                        req.port  <= pick_d ? PORT_D : PORT_I;
                        req.wr    <= pick_d & (|dmem_wmask);
                        req.off   <= win_addr[OFF_W-1:2];
                        req.wmask <= pick_d ? dmem_wmask : 4'b0;
                        req.wdata <= dmem_wdata;
                        line      <= {win_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bmem_addr <= {win_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bmem_read <= 1'b1;
                        cnt       <= '0;
                        state     <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= RD_BEATS;
                    end
                end
                RD_BEATS: begin
                    if (beat_ok) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BURST_LEN - 1)) begin
                            cnt <= '0;
                            if (req.wr) begin
                                line_buf   <= merged_buf;
                                bmem_write <= 1'b1;
                                bmem_wdata <= merged_buf[0];
                                state      <= WR_BEATS;
                            end else begin
                                line_buf <= fill_buf;
                                state    <= RESP;
                                if (req.port == PORT_D) begin
                                    dmem_resp  <= 1'b1;
                                    dmem_rdata <= old_word;
                                end else begin
                                    imem_resp  <= 1'b1;
                                    imem_rdata <= old_word;
                                end
                            end
                        end else begin
                            line_buf <= fill_buf;
                        end
                    end
                end
                WR_BEATS: begin
                    if (bmem_ready) begin
                        if (cnt == CNT_W'(BURST_LEN - 1)) begin
                            cnt        <= '0;
                            bmem_write <= 1'b0;
                            state      <= RESP;
                            // Only dmem stores; line_buf already holds the merge.
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= old_word;
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            bmem_wdata <= line_buf[cnt + CNT_W'(1)];
                        end
                    end
                end
                RESP: begin
                    imem_resp <= 1'b0;
                    dmem_resp <= 1'b0;
`ifdef MEM_ARB_RR_EN
                    rr_ptr    <= (req.port == PORT_D) ? PORT_I : PORT_D;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_responder.sv
// Directed scoreboard bench for mem_port_responder. Stimulus pushes the
// expected responses and write beats into queues. A monitor pops and
// compares them whenever the DUT presents a resp or an accepted write beat.
module tb_mem_port_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        imem_resp, dmem_resp;
    logic [31:0] bmem_addr, bmem_raddr;
    logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0] bmem_wdata, bmem_rdata;

    always #5 clk = ~clk;

    mem_port_responder dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        resp_q[$];
    logic [63:0] wbeat_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: sample 1 time unit after the falling edge, away from posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("rd_wr_excl", 64'(bmem_read & bmem_write), 64'd0);
            if (imem_resp || dmem_resp) begin
                chk("resp_both", 64'(imem_resp & dmem_resp), 64'd0);
                chk("resp_expected", 64'(resp_q.size() != 0), 64'd1);
                if (resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    chk("resp_port", 64'(dmem_resp), 64'(e.is_d));
                    chk("resp_data", 64'(dmem_resp ? dmem_rdata : imem_rdata), 64'(e.data));
                end
            end
            if (bmem_write && bmem_ready) begin
                chk("wbeat_expected", 64'(wbeat_q.size() != 0), 64'd1);
                if (wbeat_q.size() != 0) chk("wbeat_data", bmem_wdata, wbeat_q.pop_front());
            end
        end
    end

    // CPU side: drop a request once its resp is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_resp) imem_rmask = 4'b0;
            if (dmem_resp) begin
                dmem_rmask = 4'b0;
                dmem_wmask = 4'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Serves one line read: waits for the command, optionally stalls it,
    // returns nbeats beats, and optionally interleaves a foreign beat
    // before good beat bad_at. Returns the number of falling edges it
    // waited for the command. Ends on the falling edge after the last beat.
    task automatic serve_line(input logic [31:0] line_a, input logic [3:0][63:0] beats,
                              input int cmd_stall, input int bad_at, input int nbeats,
                              output int lat);
        int n = 0;
        while (!bmem_read && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk("cmd_seen", 64'(bmem_read), 64'd1);
        chk("cmd_addr", 64'(bmem_addr), 64'(line_a));
        repeat (cmd_stall) begin
            @(negedge clk);
            chk("cmd_hold", {31'd0, bmem_read, bmem_addr}, {31'd0, 1'b1, line_a});
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready = 1'b0;
        chk("cmd_drop", 64'(bmem_read), 64'd0);
        for (int k = 0; k < nbeats; k++) begin
            if (k == bad_at) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'h80;
                bmem_rdata  = 64'hBAD0_BAD1_BAD2_BAD3;
                @(negedge clk);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = line_a;
            bmem_rdata  = beats[k];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
    endtask

    // Drains the write-back beats. Optionally stalls the third beat.
    task automatic serve_write(input int wr_stall);
        int          n = 0;
        logic [63:0] held;
        while (!bmem_write && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wr_seen", 64'(bmem_write), 64'd1);
        bmem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j == 2 && wr_stall > 0) begin
                bmem_ready = 1'b0;
                held = bmem_wdata;
                repeat (wr_stall) begin
                    @(negedge clk);
                    chk("wr_hold", {bmem_write, bmem_wdata[62:0]}, {1'b1, held[62:0]});
                end
                bmem_ready = 1'b1;
            end
            @(negedge clk);
        end
        bmem_ready = 1'b0;
    endtask

    task automatic push_resp(input bit is_d, input logic [31:0] d);
        exp_t e;
        e.is_d = is_d;
        e.data = d;
        resp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {60'd0, imem_resp, dmem_resp, bmem_read, bmem_write}, 64'd0);
        chk({nm, "_baddr"}, 64'(bmem_addr), 64'd0);
        chk({nm, "_bwdata"}, bmem_wdata, 64'd0);
        chk({nm, "_rdata"}, {imem_rdata, dmem_rdata}, 64'd0);
    endtask

    logic [3:0][63:0] b;
    logic [3:0][63:0] bi, bd;
    int               lat;

    initial begin
        imem_addr = '0; imem_rmask = '0;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // imem read of beat 3, lower half
        b = {64'h7777_7777_6666_6666, 64'h5555_5555_4444_4444,
             64'h3333_3333_2222_2222, 64'h1111_1111_0000_0000};
        push_resp(1'b0, 32'h6666_6666);
        imem_addr = 32'h1234_5678; imem_rmask = 4'hF;
        serve_line(32'h1234_5660, b, 0, -1, 4, lat);
        chk("rd_cmd_latency", 64'(lat), 64'd1);
        chk("rd_resp_latency", 64'(imem_resp), 64'd1);
        repeat (3) @(negedge clk);

        // dmem store of bytes 1,2 into beat 0; wmask overrides rmask
        b = {64'h0000_0000_0000_0001, 64'hFEDC_BA98_7654_3210,
             64'h0123_4567_89AB_CDEF, 64'h0};
        push_resp(1'b1, 32'h00BB_CC00);
        wbeat_q.push_back(64'h0000_0000_00BB_CC00);
        wbeat_q.push_back(64'h0123_4567_89AB_CDEF);
        wbeat_q.push_back(64'hFEDC_BA98_7654_3210);
        wbeat_q.push_back(64'h0000_0000_0000_0001);
        dmem_addr = 32'h40; dmem_wmask = 4'b0110; dmem_rmask = 4'hF; dmem_wdata = 32'hAABB_CCDD;
        serve_line(32'h40, b, 0, -1, 4, lat);
        serve_write(0);
        repeat (3) @(negedge clk);

        // Store into beat 1 upper half, with command and write-beat stalls.
        // Address bits [1:0] are nonzero and must be ignored.
        b = {64'hE0E1_E2E3_E4E5_E6E7, 64'hD0D1_D2D3_D4D5_D6D7,
             64'hA0A1_A2A3_B0B1_B2B3, 64'hC0C1_C2C3_C4C5_C6C7};
        push_resp(1'b1, 32'h11A1_A244);
        wbeat_q.push_back(64'hC0C1_C2C3_C4C5_C6C7);
        wbeat_q.push_back(64'h11A1_A244_B0B1_B2B3);
        wbeat_q.push_back(64'hD0D1_D2D3_D4D5_D6D7);
        wbeat_q.push_back(64'hE0E1_E2E3_E4E5_E6E7);
        dmem_addr = 32'h2000_004E; dmem_wmask = 4'b1001; dmem_rmask = 4'h0; dmem_wdata = 32'h1122_3344;
        serve_line(32'h2000_0040, b, 3, -1, 4, lat);
        serve_write(3);
        repeat (3) @(negedge clk);

        // dmem read with a foreign-line beat interleaved ahead of beat 0
        b = {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000,
             64'h2222_0000_2222_0000, 64'h8765_4321_1234_5678};
        push_resp(1'b1, 32'h8765_4321);
        dmem_addr = 32'h44; dmem_rmask = 4'b0001;
        serve_line(32'h40, b, 0, 0, 4, lat);
        repeat (3) @(negedge clk);

        // Reset after two beats: no resp, outputs cleared, stale beats ignored
        b = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
             64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        imem_addr = 32'h300; imem_rmask = 4'hF;
        serve_line(32'h300, b, 0, -1, 2, lat);
        rst = 1'b1; imem_rmask = 4'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h300; bmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        chk("idle_after_reset", {62'd0, bmem_read, imem_resp}, 64'd0);

        // Follow-up request on the same line: beat 2, lower half
        b = {64'h7070_7070_8080_8080, 64'h5050_5050_6060_6060,
             64'h3030_3030_4040_4040, 64'h1010_1010_2020_2020};
        push_resp(1'b0, 32'h6060_6060);
        imem_addr = 32'h310; imem_rmask = 4'hF;
        serve_line(32'h300, b, 0, -1, 4, lat);
        repeat (3) @(negedge clk);

        // Simultaneous requests, two rounds, starting from reset
        do_reset();
        @(negedge clk);
        bi = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
              64'h9999_9999_1234_5001, 64'h0101_0101_0101_0101};
        bd = {64'h0707_0707_0707_0707, 64'hCAFE_0002_0BAD_0002,
              64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505};
        for (int r = 0; r < 2; r++) begin
`ifdef MEM_ARB_RR_EN
            push_resp(1'b0, 32'h1234_5001);
            push_resp(1'b1, 32'hCAFE_0002);
`else
            push_resp(1'b1, 32'hCAFE_0002);
            push_resp(1'b0, 32'h1234_5001);
`endif
            imem_addr = 32'h1008; imem_rmask = 4'hF;
            dmem_addr = 32'h2014; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
`ifdef MEM_ARB_RR_EN
            serve_line(32'h1000, bi, 0, -1, 4, lat);
            serve_line(32'h2000, bd, 0, -1, 4, lat);
`else
            serve_line(32'h2000, bd, 0, -1, 4, lat);
            serve_line(32'h1000, bi, 0, -1, 4, lat);
`endif
            repeat (3) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        chk("wbeat_q_drained", 64'(wbeat_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
